// File: rtl/icache_fill_if.sv
// icache_fill fetch bundle: datapath fetch port plus memory read channel.
// The slave side is the cache, the master side drives fetches and memory.
interface icache_fill_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  modport slave (
    input  imemREN, imemaddr, iload, iwait,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iload, iwait,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_fill.sv
// icache_fill: direct-mapped read-only instruction cache, two-word blocks.
// Misses fill both words from memory before the frame becomes valid.
module icache_fill #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_fill_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 29 - IDXW;

  typedef enum logic [1:0] {
    IDLE,
    FETCH0,
    FETCH1
  } state_t;

  state_t            state;
  logic [SETS-1:0]   valid;
  logic [TAGW-1:0]   tags  [SETS];
  logic [31:0]       data0 [SETS];
  logic [31:0]       data1 [SETS];
  logic [TAGW-1:0]   mtag;
  logic [IDXW-1:0]   midx;
  logic              ren;
  logic [31:0]       raddr;

  logic [IDXW-1:0]   idx;
  logic [TAGW-1:0]   atag;
  logic              bo;
  logic              hit;
  logic              unused;

  assign idx    = bus.imemaddr[2+IDXW:3];
  assign atag   = bus.imemaddr[31:3+IDXW];
  assign bo     = bus.imemaddr[2];
  assign unused = ^bus.imemaddr[1:0];

  assign hit = (state == IDLE) && bus.imemREN
            && valid[idx] && (tags[idx] == atag);

  assign bus.ihit     = hit;
  assign bus.imemload = bo ? data1[idx] : data0[idx];
  assign bus.iREN     = ren;
  assign bus.iaddr    = raddr;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      valid      <= '0;
      mtag       <= '0;
      midx       <= '0;
      ren        <= 1'b0;
      raddr      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && !(&hit_count))
        hit_count <= hit_count + 32'd1;
      unique case (state)
        IDLE: begin
          if (bus.imemREN && !hit) begin
            state <= FETCH0;
            mtag  <= atag;
            midx  <= idx;
            ren   <= 1'b1;
            raddr <= {atag, idx, 3'b000};
            if (!(&miss_count))
              miss_count <= miss_count + 32'd1;
          end
        end
        FETCH0: begin
          if (!bus.iwait) begin
            state <= FETCH1;
            raddr <= {mtag, midx, 3'b100};
          end
        end
        FETCH1: begin
          if (!bus.iwait) begin
            state       <= IDLE;
            valid[midx] <= 1'b1;
            ren         <= 1'b0;
            raddr       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload arrays carry no reset; valid alone guards them.
  always_ff @(posedge CLK) begin
    if (nRST && !bus.iwait) begin
      if (state == FETCH0)
        data0[midx] <= bus.iload;
      if (state == FETCH1) begin
        data1[midx] <= bus.iload;
        tags[midx]  <= mtag;
      end
    end
  end
endmodule

// File: tb/tb_icache_fill.sv
// tb_icache_fill: scoreboard bench with a wait-state memory model.
// Expected fetch data is queued at request time and popped on ihit.
module tb_icache_fill;
  logic        CLK;
  logic        nRST;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_fill_if bus ();

  icache_fill #(.SETS(16)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus.slave),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_wait = 0;
  logic [31:0] sb   [$];
  logic [31:0] rd_q [$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] base;
    base = a[2] ? 32'hBBBB_0004 : 32'hAAAA_0000;
    return base ^ (a & ~32'h47);
  endfunction

  // Memory model: mem_wait busy cycles per word, junk while busy.
  int          wcnt = 0;
  bit          have = 0;
  logic [31:0] hold;
  always @(posedge CLK) begin
    #1;
    if (!bus.iREN) begin
      wcnt = 0;
      have = 0;
      bus.iwait = 1'b1;
      bus.iload = 32'hDEAD_BEEF;
    end else begin
      if (have) check("iaddr_hold", bus.iaddr, hold);
      if (wcnt < mem_wait) begin
        bus.iwait = 1'b1;
        bus.iload = 32'hDEAD_BEEF;
        wcnt++;
        hold = bus.iaddr;
        have = 1;
      end else begin
        bus.iwait = 1'b0;
        bus.iload = mem_word(bus.iaddr);
        rd_q.push_back(bus.iaddr);
        wcnt = 0;
        have = 0;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input int lat);
    int n;
    bit got;
    logic [31:0] exp;
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    sb.push_back(mem_word(a));
    n   = 0;
    got = 0;
    while (!got && n < 64) begin
      @(negedge CLK);
      if (bus.ihit) got = 1;
      else begin
        @(posedge CLK); #1;
        n++;
      end
    end
    if (got) begin
      exp = sb.pop_front();
      check("imemload", bus.imemload, exp);
      check("latency", n, lat);
      @(posedge CLK); #1;
    end else begin
      check("ihit_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    bus.imemREN = 1'b0;
  endtask

  task automatic counts(input logic [31:0] h, input logic [31:0] m);
    check("hit_count", hit_count, h);
    check("miss_count", miss_count, m);
  endtask

  initial begin
    int k;
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    check("rst_ihit", bus.ihit, 1'b0);
    check("rst_iREN", bus.iREN, 1'b0);
    check("rst_iaddr", bus.iaddr, 32'd0);
    counts(0, 0);
    @(posedge CLK); #1;

    // cold miss then spatial hit
    fetch(32'h44, 3);
    check("rd_count", rd_q.size(), 2);
    check("rd0", rd_q[0], 32'h40);
    check("rd1", rd_q[1], 32'h44);
    counts(1, 1);
    fetch(32'h40, 0);
    check("spatial_no_rd", rd_q.size(), 2);
    counts(2, 1);

    // conflict at idx 8
    fetch(32'hC0, 3);
    fetch(32'h40, 3);
    check("conflict_rds", rd_q.size(), 6);
    counts(4, 3);

    // stretched memory
    mem_wait = 4;
    fetch(32'h200, 11);
    counts(5, 4);
    mem_wait = 0;

    // request withdrawn during FETCH0
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h308;
    @(posedge CLK); #1;
    bus.imemREN = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    fetch(32'h308, 0);
    counts(6, 5);

    // reset during FETCH1
    mem_wait = 4;
    rd_q.delete();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h410;
    @(posedge CLK); #1;
    bus.imemREN = 1'b0;
    k = 0;
    while (rd_q.size() == 0 && k < 40) begin
      @(negedge CLK);
      k++;
    end
    check("word0_seen", rd_q.size(), 1);
    @(posedge CLK); #1;
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("midrst_iREN", bus.iREN, 1'b0);
    counts(0, 0);
    @(posedge CLK); #1;
    rd_q.delete();
    fetch(32'h410, 11);
    check("refill_rds", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      check("refill0", rd_q[0], 32'h410);
      check("refill1", rd_q[1], 32'h414);
    end
    counts(1, 1);
    @(negedge CLK);
    check("idle_iaddr", bus.iaddr, 32'd0);
    check("idle_ihit", bus.ihit, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
